// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states,
// trap causes, ALU class codes and the decoded control bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BR    = 3'b001;
  localparam logic [2:0] ALU_R     = 3'b010;
  localparam logic [2:0] ALU_I     = 3'b011;
  localparam logic [2:0] ALU_JMP   = 3'b100;
  localparam logic [2:0] ALU_IMM   = 3'b101;
  localparam logic [2:0] ALU_AUIPC = 3'b110;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_ILLEGAL = 2'b01,
    TRAP_IMEM_TO = 2'b10,
    TRAP_DMEM_TO = 2'b11
  } trap_e;

  // is_load/is_store/wr_en steer the FSM and strobes; the rest go straight out.
  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc1;
    logic       alusrc2;
    logic       memtoreg;
    logic       lui;
    logic       pcsrc;
    logic       branch;
    logic       jump;
    logic       is_load;
    logic       is_store;
    logic       wr_en;
  } ctrl_t;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction/data memory handshake between the controller and the memories.
interface rv_multicycle_ctrl_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_ready;

  modport master (output imem_req, dmem_req, input imem_ready, imem_rdata, dmem_ready);
  modport slave  (input imem_req, dmem_req, output imem_ready, imem_rdata, dmem_ready);
endinterface

// File: rtl/rv_multicycle_ctrl_decode.sv
// Combinational opcode decode into the control bundle; flags unknown opcodes.
module rv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  // One entry per supported opcode; anything else is illegal with a null bundle.
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LUI:    begin ctrl_o.aluop = ALU_IMM;   ctrl_o.alusrc2 = 1'b1; ctrl_o.lui = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_AUIPC:  begin ctrl_o.aluop = ALU_AUIPC; ctrl_o.alusrc1 = 1'b1; ctrl_o.alusrc2 = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_JAL:    begin ctrl_o.aluop = ALU_JMP;   ctrl_o.alusrc1 = 1'b1; ctrl_o.alusrc2 = 1'b1;
                        ctrl_o.jump = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_JALR:   begin ctrl_o.aluop = ALU_JMP;   ctrl_o.alusrc2 = 1'b1; ctrl_o.pcsrc = 1'b1;
                        ctrl_o.jump = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_BRANCH: begin ctrl_o.aluop = ALU_BR;    ctrl_o.branch = 1'b1; end
      OPC_LOAD:   begin ctrl_o.aluop = ALU_ADD;   ctrl_o.alusrc2 = 1'b1; ctrl_o.memtoreg = 1'b1;
                        ctrl_o.is_load = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_STORE:  begin ctrl_o.aluop = ALU_ADD;   ctrl_o.alusrc2 = 1'b1; ctrl_o.is_store = 1'b1; end
      OPC_OPIMM:  begin ctrl_o.aluop = ALU_I;     ctrl_o.alusrc2 = 1'b1; ctrl_o.wr_en = 1'b1; end
      OPC_OP:     begin ctrl_o.aluop = ALU_R;     ctrl_o.wr_en = 1'b1; end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a
// sticky TRAP state, memory wait timeout and cycle/retired counters.
module rv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  rv_multicycle_ctrl_if.master mem,
  output logic [XLEN-1:0]  ir,
  output logic             pc_we,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic [2:0]       aluop,
  output logic             alusrc1,
  output logic             alusrc2,
  output logic             memtoreg,
  output logic             lui,
  output logic             pcsrc,
  output logic             branch,
  output logic             jump,
  output logic [2:0]       state_out,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  logic             dec_illegal;
  trap_e            cause_q, cause_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             issued_q, issued_d;
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic             ireq, dreq, timeout_hit;

  rv_ctrl_decode u_dec (
    .opcode_i  (ir_q[6:0]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Hitting the last allowed wait cycle with ready still low is a timeout.
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == TO_LAST);

  // Next state, handshake requests and one-cycle strobes.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cause_d  = cause_q;
    issued_d = 1'b0;
    ireq     = 1'b0;
    dreq     = 1'b0;
    pc_we    = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Once issued the request no longer depends on run; rst gating keeps
        // it low while reset is held even though state already reads FETCH.
        ireq = (run | issued_q) & rst;
        if (ireq) begin
          if (mem.imem_ready) begin
            ir_d    = mem.imem_rdata;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_TRAP;
            cause_d = TRAP_IMEM_TO;
          end else begin
            issued_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = (ctrl_q.is_load | ctrl_q.is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dreq     = 1'b1;
        memread  = ctrl_q.is_load;
        memwrite = ctrl_q.is_store;
        if (mem.dmem_ready) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = TRAP_DMEM_TO;
        end
      end
      S_WB: begin
        pc_we    = 1'b1;
        regwrite = ctrl_q.wr_en;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Wait counter clears on any state change, counts cycles spent stalled.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if ((ireq & ~mem.imem_ready) | (dreq & ~mem.dmem_ready))
      wait_d = wait_q + 1'b1;
  end

  // Control bundle is captured at DECODE and held only while in EXECUTE..WB.
  always_comb begin
    ctrl_d = '0;
    if (state_d inside {S_EXECUTE, S_MEM, S_WB})
      ctrl_d = (state_q == S_DECODE) ? dec_ctrl : ctrl_q;
  end

  // State, IR, control, wait and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      ctrl_q   <= '0;
      cause_q  <= TRAP_NONE;
      wait_q   <= '0;
      issued_q <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ctrl_q   <= ctrl_d;
      cause_q  <= cause_d;
      wait_q   <= wait_d;
      issued_q <= issued_d;
      if (state_q != S_TRAP) cyc_q <= cyc_q + CNT_W'(1);
      if (state_q == S_WB)   ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign mem.imem_req  = ireq;
  assign mem.dmem_req  = dreq;
  assign ir            = ir_q;
  assign aluop         = ctrl_q.aluop;
  assign alusrc1       = ctrl_q.alusrc1;
  assign alusrc2       = ctrl_q.alusrc2;
  assign memtoreg      = ctrl_q.memtoreg;
  assign lui           = ctrl_q.lui;
  assign pcsrc         = ctrl_q.pcsrc;
  assign branch        = ctrl_q.branch;
  assign jump          = ctrl_q.jump;
  assign state_out     = state_q;
  assign halted        = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign cycle_cnt     = cyc_q;
  assign instret_cnt   = ret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: a per-cycle expectation derived from the
// instruction sequence, compared on every falling edge, plus literal pins.
module tb_rv_multicycle_ctrl;
  import riscv_pkg::*;

  localparam int XLEN = 32, CNT_W = 4, TIMEOUT = 8, TO_W = 8;

  logic clk = 1'b0, rst = 1'b0, run = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.XLEN(XLEN)) mif ();

  logic [XLEN-1:0]  ir;
  logic             pc_we, regwrite, memread, memwrite, alusrc1, alusrc2, memtoreg;
  logic             lui, pcsrc, branch, jump, halted;
  logic [2:0]       aluop, state_out;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  rv_multicycle_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .run(run), .mem(mif),
    .ir(ir), .pc_we(pc_we), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .aluop(aluop), .alusrc1(alusrc1), .alusrc2(alusrc2), .memtoreg(memtoreg), .lui(lui),
    .pcsrc(pcsrc), .branch(branch), .jump(jump), .state_out(state_out), .halted(halted),
    .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  int checks = 0, fails = 0, dreq_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Expected control vector {aluop, src1, src2, memtoreg, lui, pcsrc, branch, jump}.
  function automatic logic [9:0] exp_ctrl(input logic [6:0] op);
    case (op)
      7'h37:   return {3'd5, 7'b0101000};
      7'h17:   return {3'd6, 7'b1100000};
      7'h6F:   return {3'd4, 7'b1100001};
      7'h67:   return {3'd4, 7'b0100101};
      7'h63:   return {3'd1, 7'b0000010};
      7'h03:   return {3'd0, 7'b0110000};
      7'h23:   return {3'd0, 7'b0100000};
      7'h13:   return {3'd3, 7'b0100000};
      7'h33:   return {3'd2, 7'b0000000};
      default: return 10'd0;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  st;
    logic        ireq, dreq, pcwe, rw, mrd, mwr, hlt;
    logic [9:0]  ctrl;
    logic [1:0]  cause;
    logic [31:0] ir;
    int          cyc, ret;
  } exp_t;

  exp_t        e;
  bit          e_vld = 0;
  logic [31:0] m_ir = 0;
  int          m_cyc = 0, m_ret = 0;
  logic [1:0]  m_cause = 0;

  // One cycle: drive inputs, publish what the outputs must be, advance the model.
  task automatic cyc(input logic [2:0] st, input bit ireq, input bit run_v,
                     input bit iready, input bit dready, input logic [31:0] rdata);
    logic [6:0] op;
    op = m_ir[6:0];
    run = run_v; mif.imem_ready = iready; mif.dmem_ready = dready; mif.imem_rdata = rdata;
    e.st    = st;
    e.ireq  = ireq;
    e.dreq  = (st == S_MEM);
    e.mrd   = (st == S_MEM) && (op == 7'h03);
    e.mwr   = (st == S_MEM) && (op == 7'h23);
    e.pcwe  = (st == S_WB);
    e.rw    = (st == S_WB) && (op != 7'h63) && (op != 7'h23);
    e.ctrl  = (st == S_EXECUTE || st == S_MEM || st == S_WB) ? exp_ctrl(op) : 10'd0;
    e.hlt   = (st == S_TRAP);
    e.cause = m_cause;
    e.ir    = m_ir;
    e.cyc   = m_cyc;
    e.ret   = m_ret;
    e_vld   = 1;
    @(posedge clk);
    if (st != S_TRAP) m_cyc = (m_cyc + 1) % 16;
    if (st == S_WB)   m_ret = (m_ret + 1) % 16;
    if (st == S_FETCH && ireq && iready) m_ir = rdata;
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input bit drop_run);
    bit ismem;
    ismem = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
    for (int i = 0; i < iw; i++) cyc(S_FETCH, 1, (i == 0) || !drop_run, 0, 0, ins);
    cyc(S_FETCH, 1, (iw == 0) || !drop_run, 1, 0, ins);
    cyc(S_DECODE, 0, 1, 0, 0, 0);
    cyc(S_EXECUTE, 0, 1, 0, 0, 0);
    if (ismem) begin
      for (int i = 0; i < dw; i++) cyc(S_MEM, 0, 1, 0, 0, 0);
      cyc(S_MEM, 0, 1, 0, 1, 0);
    end
    cyc(S_WB, 0, 1, 0, 0, 0);
  endtask

  // Reset is asserted mid-cycle and its effect checked before any clock edge.
  task automatic do_reset();
    e_vld = 0;
    mif.dmem_ready = 0; mif.imem_ready = 0;
    #2 rst = 0;
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_imem_req", mif.imem_req, 0);
    chk("rst_dmem_req", mif.dmem_req, 0);
    chk("rst_memread", memread, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_ir", ir, 0);
    @(posedge clk); #1;
    rst = 1;
    m_cyc = 0; m_ret = 0; m_ir = 0; m_cause = 0;
  endtask

  always @(negedge clk) begin
    if (mif.dmem_req) dreq_n++;
    if (e_vld) begin
      chk("state", state_out, e.st);
      chk("imem_req", mif.imem_req, e.ireq);
      chk("dmem_req", mif.dmem_req, e.dreq);
      chk("memread", memread, e.mrd);
      chk("memwrite", memwrite, e.mwr);
      chk("pc_we", pc_we, e.pcwe);
      chk("regwrite", regwrite, e.rw);
      chk("ctrl", {aluop, alusrc1, alusrc2, memtoreg, lui, pcsrc, branch, jump}, e.ctrl);
      chk("halted", halted, e.hlt);
      chk("trap_cause", trap_cause, e.cause);
      chk("ir", ir, e.ir);
      chk("cycle_cnt", cycle_cnt, e.cyc);
      chk("instret_cnt", instret_cnt, e.ret);
    end
  end

  initial begin
    mif.imem_ready = 0; mif.dmem_ready = 0; mif.imem_rdata = 0;
    run = 1;
    do_reset();

    // ADDI x1,x0,5 with ready tied high: 4 cycles.
    run_instr(32'h00500093, 0, 0, 0);
    chk("addi_cycle_cnt", cycle_cnt, 4);
    chk("addi_instret", instret_cnt, 1);

    // LW with two data wait cycles: 7 cycles, dmem_req high for 3.
    do_reset();
    dreq_n = 0;
    run_instr(32'h0000A103, 0, 2, 0);
    chk("lw_cycle_cnt", cycle_cnt, 7);
    chk("lw_dreq_cycles", dreq_n, 3);

    // Idle with run low, then SW whose fetch outlives a dropped run.
    cyc(S_FETCH, 0, 0, 0, 0, 0);
    cyc(S_FETCH, 0, 0, 0, 0, 0);
    run_instr(32'h00202223, 2, 0, 1);
    chk("sw_instret", instret_cnt, 2);

    // Remaining opcode classes; ready on the 8th fetch cycle still succeeds.
    run_instr(32'h002081B3, 0, 0, 0);
    run_instr(32'h00000063, 1, 0, 0);
    run_instr(32'h000000EF, 0, 0, 0);
    run_instr(32'h00008067, 0, 0, 0);
    run_instr(32'h000012B7, 7, 0, 0);
    run_instr(32'h00001297, 0, 0, 0);

    // Four 4-cycle instructions wrap the 4-bit cycle counter back to 0.
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(32'h00500093, 0, 0, 0);
    chk("wrap_cycle_cnt", cycle_cnt, 0);
    chk("wrap_instret", instret_cnt, 4);

    // Reset while stalled in MEM drops the request asynchronously.
    cyc(S_FETCH, 1, 1, 1, 0, 32'h0000A103);
    cyc(S_DECODE, 0, 1, 0, 0, 0);
    cyc(S_EXECUTE, 0, 1, 0, 0, 0);
    cyc(S_MEM, 0, 1, 0, 0, 0);
    e_vld = 0;
    chk("midmem_dmem_req_pre", mif.dmem_req, 1);
    chk("midmem_memread_pre", memread, 1);
    do_reset();
    run_instr(32'h00500093, 0, 0, 0);

    // Illegal opcode traps after DECODE and freezes the counters.
    do_reset();
    cyc(S_FETCH, 1, 1, 1, 0, 32'h0000007F);
    cyc(S_DECODE, 0, 1, 0, 0, 0);
    m_cause = 2'b01;
    for (int i = 0; i < 4; i++) cyc(S_TRAP, 0, 1, 0, 0, 0);
    chk("ill_cycle_cnt", cycle_cnt, 2);
    chk("ill_cause", trap_cause, 1);

    // Fetch timeout: 8 request cycles, then TRAP with the request dropped.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(S_FETCH, 1, 1, 0, 0, 0);
    m_cause = 2'b10;
    for (int i = 0; i < 3; i++) cyc(S_TRAP, 0, 1, 0, 0, 0);
    chk("ito_cycle_cnt", cycle_cnt, 8);
    chk("ito_imem_req", mif.imem_req, 0);

    // Data timeout.
    do_reset();
    cyc(S_FETCH, 1, 1, 1, 0, 32'h0000A103);
    cyc(S_DECODE, 0, 1, 0, 0, 0);
    cyc(S_EXECUTE, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(S_MEM, 0, 1, 0, 0, 0);
    m_cause = 2'b11;
    for (int i = 0; i < 2; i++) cyc(S_TRAP, 0, 1, 0, 0, 0);
    chk("dto_cycle_cnt", cycle_cnt, 11);
    chk("dto_cause", trap_cause, 3);

    e_vld = 0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
